// File: rtl/l2_norm_datapath.sv
// Arithmetic core of the L2-norm block: a combinational 8-lane squarer/adder and a
// sequential Newton-iteration integer square root with start/done/available handshake.
module l2_norm_datapath (
  input  logic          clock,
  input  logic          reset,
  input  logic [63:0]   data_in,
  output logic [127:0]  squares_out,
  output logic [31:0]   sum_out,
  input  logic [31:0]   sqrt_in,
  input  logic          start,
  output logic [31:0]   sqrt_out,
  output logic          done,
  output logic          available
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_UPD  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic [4:0] msb_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  logic [15:0] sq_s [8];
  logic [31:0] sum_s;

  // Lane squares and their sum; 8 * 0xFE01 fits well inside 32 bits.
  always_comb begin
    sum_s       = 32'd0;
    squares_out = 128'd0;
    for (int i = 0; i < 8; i++) begin
      sq_s[i] = {8'd0, data_in[8*i +: 8]} * {8'd0, data_in[8*i +: 8]};
      squares_out[16*i +: 16] = sq_s[i];
      sum_s = sum_s + {16'd0, sq_s[i]};
    end
  end

  assign sum_out = sum_s;

  logic [2:0]  state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] x_q, x_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] sqrt_q, sqrt_d;
  logic        done_q, done_d;
  logic        avail_q, avail_d;

  logic [32:0] trial_s;
  logic [32:0] xn_s;
  logic [4:0]  msb_s;
  logic [31:0] x_init_s;

  assign trial_s  = {rem_q, quo_q[31]} - {1'b0, x_q};
  assign xn_s     = ({1'b0, x_q} + {1'b0, quo_q}) >> 1;
  assign msb_s    = msb_index(n_q);
  // Power of two at or above sqrt(n): 2^(floor(msb/2)+1).
  assign x_init_s = 32'd1 << ({1'b0, msb_s[4:1]} + 5'd1);

  // Square-root FSM next state: latch, seed, restoring divide, Newton update.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    x_d     = x_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sqrt_d  = sqrt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = sqrt_in;
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (n_q == 32'd0) begin
          sqrt_d  = 32'd0;
          state_d = ST_DONE;
        end else begin
          x_d     = x_init_s;
          rem_d   = 32'd0;
          quo_d   = n_q;
          cnt_d   = 5'd0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        // Remainder stays below x (<= 65536), so 32 bits never overflow here.
        if (!trial_s[32]) begin
          rem_d = trial_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd31) begin
          state_d = ST_UPD;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_UPD: begin
        if (xn_s >= {1'b0, x_q}) begin
          sqrt_d  = x_q;
          state_d = ST_DONE;
        end else begin
          x_d     = xn_s[31:0];
          rem_d   = 32'd0;
          quo_d   = n_q;
          cnt_d   = 5'd0;
          state_d = ST_DIV;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d  = (state_d == ST_DONE);
    avail_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= 32'd0;
      x_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      cnt_q   <= 5'd0;
      sqrt_q  <= 32'd0;
      done_q  <= 1'b0;
      avail_q <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sqrt_q  <= sqrt_d;
      done_q  <= done_d;
      avail_q <= avail_d;
    end
  end

  assign sqrt_out  = sqrt_q;
  assign done      = done_q;
  assign available = avail_q;

endmodule

// File: tb/tb_l2_norm_datapath.sv
// Directed self-checking bench for l2_norm_datapath: squarer/sum vectors and
// square-root handshake scenarios with hand-computed expected values.
module tb_l2_norm_datapath;

  logic          clock;
  logic          reset;
  logic [63:0]   data_in;
  logic [127:0]  squares_out;
  logic [31:0]   sum_out;
  logic [31:0]   sqrt_in;
  logic          start;
  logic [31:0]   sqrt_out;
  logic          done;
  logic          available;

  int total;
  int bad;

  l2_norm_datapath dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .squares_out (squares_out),
    .sum_out     (sum_out),
    .sqrt_in     (sqrt_in),
    .start       (start),
    .sqrt_out    (sqrt_out),
    .done        (done),
    .available   (available)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Waits for done with a cycle bound; checks available stays low while busy.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int cyc;
    int busy_bad;
    cyc = 0;
    busy_bad = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (!done && available) busy_bad++;
    end while (!done && cyc < 400);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat_ok"}, 32'(cyc <= 300), 32'd1);
    chk({tag, "_busy_avail"}, 32'(busy_bad), 32'd0);
    chk({tag, "_root"}, sqrt_out, exp);
  endtask

  task automatic run_sqrt(input string tag, input logic [31:0] v, input logic [31:0] exp);
    sqrt_in = v;
    start = 1'b1;
    wait_done(tag, exp);
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    @(negedge clock);
    chk({tag, "_rel_avail"}, 32'(available), 32'd1);
    chk({tag, "_rel_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [63:0] vec;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    sqrt_in = 32'd0;
    data_in = 64'd0;
    repeat (2) @(negedge clock);
    chk("rst_sqrt", sqrt_out, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_avail", 32'(available), 32'd1);
    reset = 1'b0;

    data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("ff_lane%0d", i), 32'(squares_out[16*i +: 16]), 32'h0000_FE01);
    chk("ff_sum", sum_out, 32'h0007_F008);

    data_in = 64'h0807_0605_0403_0201;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("seq_lane%0d", i), 32'(squares_out[16*i +: 16]), 32'((i + 1) * (i + 1)));
    chk("seq_sum", sum_out, 32'd204);

    vec = 64'h00FF_0010_0080_0003;
    data_in = vec;
    #1;
    chk("mix_lane0", 32'(squares_out[15:0]), 32'd9);
    chk("mix_lane2", 32'(squares_out[47:32]), 32'h0000_4000);
    chk("mix_lane6", 32'(squares_out[111:96]), 32'd65025);
    chk("mix_sum", sum_out, 32'd81674);

    data_in = 64'd0;
    #1;
    chk("zero_sum", sum_out, 32'd0);
    chk("zero_sq", 32'(squares_out != 128'd0), 32'd0);

    run_sqrt("s0", 32'd0, 32'd0);            release_start("s0");
    run_sqrt("s1", 32'd1, 32'd1);            release_start("s1");
    run_sqrt("s15", 32'd15, 32'd3);          release_start("s15");
    run_sqrt("s16", 32'd16, 32'd4);          release_start("s16");
    run_sqrt("s520200", 32'd520200, 32'd721); release_start("s520200");
    run_sqrt("smax", 32'hFFFF_FFFF, 32'd65535);

    // Hold start through done: no restart, result stable.
    repeat (5) begin
      @(negedge clock);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_root", sqrt_out, 32'd65535);
      chk("hold_avail", 32'(available), 32'd0);
    end
    release_start("hold");
    run_sqrt("s100", 32'd100, 32'd10);       release_start("s100");

    // Radicand change and start pulse while busy are ignored.
    sqrt_in = 32'd1000000;
    start = 1'b1;
    repeat (10) @(negedge clock);
    sqrt_in = 32'd4;
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    wait_done("midchg", 32'd1000);
    release_start("midchg");

    // Reset during DIV, with start still high: reset wins.
    sqrt_in = 32'hFFFF_FFFF;
    start = 1'b1;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_sqrt", sqrt_out, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_avail", 32'(available), 32'd1);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    run_sqrt("s49", 32'd49, 32'd7);          release_start("s49");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_norm_datapath.md
Name: l2_norm_datapath

Overview:
- Arithmetic core of the L2-norm AXIS block.
- Combinational path: squares eight unsigned 8-bit lanes of a 64-bit beat and sums the squares into a 32-bit partial sum. The AXIS wrapper accumulates these partial sums.
- Sequential path: an integer square-root engine (Newton iteration with a start/done/available handshake) turns the final accumulated sum into the norm.

Parameters:
- None. All widths are fixed: 64-bit input beat, 8 lanes, 32-bit sum and root.

Ports:
- clock        input   1    single clock, rising edge
- reset        input   1    synchronous, active-high reset
- data_in      input   64   eight unsigned bytes; lane i = data_in[8i+7:8i]
- squares_out  output  128  lane i square at [16i+15:16i]
- sum_out      output  32   sum of the eight squares, zero-extended
- sqrt_in      input   32   unsigned radicand
- start        input   1    level request to compute the root of sqrt_in
- sqrt_out     output  32   floor(sqrt(radicand)), zero-extended from 16 bits
- done         output  1    result valid; held until start drops
- available    output  1    engine idle and able to accept start

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset values: sqrt_out=0, done=0, available=1, FSM in IDLE.
  - The combinational outputs do not depend on reset.
- Squarer (combinational):
  - squares_out[16i+15:16i] = lane_i * lane_i, unsigned, exact 16-bit result.
  - Lane 0xFF gives 0xFE01.
- Sum (combinational):
  - sum_out = sum of the 8 squares; maximum 520200 (0x7F008).
  - Upper bits are zero; no overflow is possible.
- Square-root FSM states:
  - IDLE: available=1, done=0. If start=1, latch sqrt_in into the radicand register n and go to INIT. Later changes on sqrt_in are ignored.
  - INIT:
    - If n==0, result=0 and go to DONE.
    - Otherwise x = 1 << (floor(msb_index(n)/2)+1), which guarantees x >= sqrt(n); go to DIV.
  - DIV: a restoring divider computes q = n / x, one quotient bit per cycle, 32 cycles. Then go to UPD.
  - UPD:
    - xn = (x + q) >> 1, using a 33-bit intermediate so the add cannot overflow.
    - If xn >= x, result = x and go to DONE.
    - Otherwise x = xn and go to DIV.
  - DONE: done=1, available=0, sqrt_out holds the result. Stay until start==0, then go to IDLE.
- Outputs while busy (INIT/DIV/UPD): available=0, done=0, sqrt_out keeps its previous value.
- Result: sqrt_out = floor(sqrt(n)) exactly for every 32-bit n. The maximum result is 65535.
- Latency from start accepted to done high: at most 300 cycles for any input.
- Handshake:
  - start is level-sensitive and is accepted only in IDLE. Asserting start while busy has no effect.
  - Because done is held, a master may drop start in the same cycle it sees done=1. The engine must not restart on that edge.
  - Holding start high through DONE does not restart. A new operation needs start low for at least one cycle, so the engine returns to IDLE first.
- Reset mid-operation: abort, return to IDLE with sqrt_out=0, done=0, available=1. The partial result is discarded.
- Simultaneous reset and start: reset wins.

Test Plan:
- data_in=0xFFFFFFFF_FFFFFFFF -> every squares_out lane = 0xFE01; sum_out = 0x0007F008 (520200).
- data_in=0x0807060504030201 -> lanes 1,4,9,...,64; sum_out=204. data_in=0 -> sum_out=0.
- Sweep sqrt_in of 0, 1, 15, 16, 520200, 0xFFFFFFFF, each with a start/done cycle:
  - 0 -> 0; 1 -> 1; 15 -> 3; 16 -> 4; 520200 -> 721; 0xFFFFFFFF -> 65535.
  - done rises within 300 cycles, with available=0 while busy.
- Hold start high after done -> done stays 1, sqrt_out stable, no restart.
- Drop start -> available=1 next cycle. Then start with 100 -> result 10.
- Change sqrt_in mid-computation and pulse start while busy -> both ignored; the result matches the latched radicand.
- Assert reset mid-DIV -> next cycle sqrt_out=0, done=0, available=1. A following start with 49 -> result 7.
